// File: rtl/pgr_uart_cmd_apb_32bit_pkg.sv
// Shared constants and FSM encoding for the UART command to APB32 engine.
package pgr_uart_cmd_apb_32bit_pkg;

    localparam logic [7:0] CMD_RD     = 8'h00;
    localparam logic [7:0] CMD_WR     = 8'h01;
    localparam logic [7:0] STS_OK     = 8'h00;
    localparam logic [7:0] STS_SLVERR = 8'h01;
    localparam logic [7:0] STS_TMO    = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RX_ADDR    = 3'd1,
        ST_RX_DATA    = 3'd2,
        ST_APB_SETUP  = 3'd3,
        ST_APB_ACCESS = 3'd4,
        ST_TX_RESP    = 3'd5
    } state_e;

    // Response length in bytes: status only for writes, status + 4 data bytes for reads.
    function automatic logic [2:0] resp_len(input logic is_wr);
        return is_wr ? 3'd1 : 3'd5;
    endfunction

endpackage

// File: rtl/pgr_cmd_timeout_cnt.sv
// Idle/wait-cycle counter with synchronous clear; expire_o flags the cycle
// in which the count would reach limit_i.
module pgr_cmd_timeout_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cnt_inc;

    assign cnt_inc  = cnt_q + {{(W-1){1'b0}}, 1'b1};
    assign expire_o = en_i & ~clr_i & (cnt_inc == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pgr_uart_cmd_apb_32bit.sv
// UART command engine: assembles read/write frames from the RX FIFO, runs one
// APB3 transfer per frame and pushes the status/read-data response to the TX FIFO.
module pgr_uart_cmd_apb_32bit
    import pgr_uart_cmd_apb_32bit_pkg::*;
#(
    parameter logic [15:0] APB_TIMEOUT = 16'd1023,
    parameter logic [23:0] RX_TIMEOUT  = 24'd500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_fifo_rd_data,
    input  logic        rx_fifo_rd_data_valid,
    output logic        rx_fifo_rd_data_req,
    output logic [7:0]  tx_fifo_wr_data,
    output logic        tx_fifo_wr_data_req,
    input  logic        tx_fifo_wr_data_valid,
    output logic        p_sel,
    output logic        p_enable,
    output logic        p_write,
    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    input  logic [31:0] p_rdata,
    input  logic        p_ready,
    input  logic        p_slverr
);

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [39:0] resp_q, resp_d;
    logic [2:0]  resp_left_q, resp_left_d;
    logic        rx_active, rx_pop, tx_push, apb_tmo, rx_tmo;

    assign rx_active           = (state_q == ST_RX_ADDR) || (state_q == ST_RX_DATA);
    assign rx_pop              = ((state_q == ST_IDLE) || rx_active) && rx_fifo_rd_data_valid;
    assign tx_push             = (state_q == ST_TX_RESP) && tx_fifo_wr_data_valid;
    assign rx_fifo_rd_data_req = rx_pop;
    assign tx_fifo_wr_data_req = tx_push;
    // Response is a shift register; the head byte is the registered TX data.
    assign tx_fifo_wr_data     = resp_q[39:32];

    assign p_sel    = (state_q == ST_APB_SETUP) || (state_q == ST_APB_ACCESS);
    assign p_enable = (state_q == ST_APB_ACCESS);
    assign p_write  = is_wr_q;
    assign p_addr   = addr_q;
    assign p_wdata  = wdata_q;

    pgr_cmd_timeout_cnt #(.W(16)) u_apb_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != ST_APB_ACCESS),
        .en_i     ((state_q == ST_APB_ACCESS) && !p_ready),
        .limit_i  (APB_TIMEOUT),
        .expire_o (apb_tmo)
    );

    pgr_cmd_timeout_cnt #(.W(24)) u_rx_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (rx_pop || !rx_active),
        .en_i     (rx_active && !rx_fifo_rd_data_valid),
        .limit_i  (RX_TIMEOUT),
        .expire_o (rx_tmo)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_pop && (rx_fifo_rd_data == CMD_WR || rx_fifo_rd_data == CMD_RD)) begin
                    is_wr_d    = (rx_fifo_rd_data == CMD_WR);
                    byte_cnt_d = 2'd0;
                    state_d    = ST_RX_ADDR;
                end
            end
            ST_RX_ADDR: begin
                if (rx_pop) begin
                    addr_d     = {addr_q[23:0], rx_fifo_rd_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = is_wr_q ? ST_RX_DATA : ST_APB_SETUP;
                end else if (rx_tmo) begin
                    byte_cnt_d = 2'd0;
                    state_d    = ST_IDLE;
                end
            end
            ST_RX_DATA: begin
                if (rx_pop) begin
                    wdata_d    = {wdata_q[23:0], rx_fifo_rd_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = ST_APB_SETUP;
                end else if (rx_tmo) begin
                    byte_cnt_d = 2'd0;
                    state_d    = ST_IDLE;
                end
            end
            ST_APB_SETUP: state_d = ST_APB_ACCESS;
            ST_APB_ACCESS: begin
                if (p_ready) begin
                    resp_d      = {p_slverr ? STS_SLVERR : STS_OK,
                                   (p_slverr || is_wr_q) ? 32'h0 : p_rdata};
                    resp_left_d = resp_len(is_wr_q);
                    state_d     = ST_TX_RESP;
                end else if (apb_tmo) begin
                    resp_d      = {STS_TMO, 32'h0};
                    resp_left_d = resp_len(is_wr_q);
                    state_d     = ST_TX_RESP;
                end
            end
            ST_TX_RESP: begin
                if (tx_push) begin
                    resp_d      = {resp_q[31:0], 8'h00};
                    resp_left_d = resp_left_q - 3'd1;
                    if (resp_left_q == 3'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= 2'd0;
            is_wr_q     <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            resp_q      <= 40'h0;
            resp_left_q <= 3'd0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
        end
    end

endmodule

// File: tb/tb_pgr_uart_cmd_apb_32bit.sv
// Scoreboard bench: frames and slave behaviour are randomised, expected APB
// transfers and TX bytes are queued at issue time and checked by monitors.
`timescale 1ns/1ps
module tb_pgr_uart_cmd_apb_32bit;

    localparam logic [15:0] APB_TMO = 16'd15;
    localparam logic [23:0] RX_TMO  = 24'd200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_fifo_rd_data;
    logic        rx_fifo_rd_data_valid, rx_fifo_rd_data_req;
    logic [7:0]  tx_fifo_wr_data;
    logic        tx_fifo_wr_data_req, tx_fifo_wr_data_valid;
    logic        p_sel, p_enable, p_write;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        p_ready, p_slverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pgr_uart_cmd_apb_32bit #(.APB_TIMEOUT(APB_TMO), .RX_TIMEOUT(RX_TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_fifo_rd_data(rx_fifo_rd_data), .rx_fifo_rd_data_valid(rx_fifo_rd_data_valid),
        .rx_fifo_rd_data_req(rx_fifo_rd_data_req),
        .tx_fifo_wr_data(tx_fifo_wr_data), .tx_fifo_wr_data_req(tx_fifo_wr_data_req),
        .tx_fifo_wr_data_valid(tx_fifo_wr_data_valid),
        .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata),
        .p_ready(p_ready), .p_slverr(p_slverr)
    );

    typedef struct { logic [7:0] b; bit first; int lat; } tx_exp_t;
    typedef struct { logic [31:0] addr; bit wr; logic [31:0] wdata; int sel_cyc; } apb_exp_t;

    tx_exp_t     tx_q[$];
    apb_exp_t    apb_q[$];
    logic [7:0]  rxq[$];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] addrs [4] = '{32'h0000_1004, 32'h0000_2000, 32'hA5A5_0010, 32'hFFFF_FFFC};

    int  cfg_ws = 0;
    bit  cfg_err = 0, cfg_hang = 0;
    bit  rx_rand = 0, tx_rand = 0, tx_hold = 0;
    int  rx_keep = 0;
    int  cyc = 0, last_pop_cyc = 0, acc = 0;
    bit  pop_now = 0;
    bit  in_sel = 0, cap_wr;
    int  sel_cnt;
    logic [31:0] cap_addr, cap_wdata;
    tx_exp_t  te;
    apb_exp_t ae;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Input drivers and APB slave, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && pop_now && rxq.size() > 0) void'(rxq.pop_front());
        rx_fifo_rd_data_valid = (rxq.size() > rx_keep) && (!rx_rand || $urandom_range(0, 2) != 0);
        rx_fifo_rd_data       = (rxq.size() > 0) ? rxq[0] : 8'h00;
        tx_fifo_wr_data_valid = !tx_hold && (!tx_rand || $urandom_range(0, 1) == 1);
        if (p_sel && p_enable) begin
            p_ready = !cfg_hang && (acc == cfg_ws);
            acc++;
        end else begin
            p_ready = 1'b0;
            acc = 0;
        end
        p_rdata  = p_ready ? (slave_mem.exists(p_addr) ? slave_mem[p_addr] : 32'h0) : $urandom;
        p_slverr = p_ready ? cfg_err : 1'($urandom_range(0, 1));
    end

    // Monitors sample mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_sel  = 0;
            pop_now = 0;
        end else begin
            if (tx_fifo_wr_data_req) begin
                chk("tx_req_needs_valid", tx_fifo_wr_data_valid, 1);
                if (tx_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_unexpected: got push of %02h, required no push", tx_fifo_wr_data);
                end else begin
                    te = tx_q.pop_front();
                    chk("tx_byte", tx_fifo_wr_data, te.b);
                    if (te.first && te.lat >= 0) chk("resp_latency", cyc - last_pop_cyc, te.lat);
                end
            end
            if (p_sel) begin
                if (!in_sel) begin
                    in_sel = 1; sel_cnt = 1;
                    cap_addr = p_addr; cap_wr = p_write; cap_wdata = p_wdata;
                    chk("setup_penable", p_enable, 0);
                end else begin
                    sel_cnt++;
                    chk("access_penable", p_enable, 1);
                    chk("addr_stable", p_addr, cap_addr);
                    chk("write_stable", p_write, cap_wr);
                    chk("wdata_stable", p_wdata, cap_wdata);
                    if (p_enable && p_ready && p_write && !p_slverr) slave_mem[p_addr] = p_wdata;
                end
            end else if (in_sel) begin
                in_sel = 0;
                if (apb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL apb_unexpected: got transfer to %08h, required none", cap_addr);
                end else begin
                    ae = apb_q.pop_front();
                    chk("apb_addr", cap_addr, ae.addr);
                    chk("apb_write", cap_wr, ae.wr);
                    if (ae.wr) chk("apb_wdata", cap_wdata, ae.wdata);
                    chk("psel_cycles", sel_cnt, ae.sel_cyc);
                end
            end
            pop_now = rx_fifo_rd_data_req;
            if (pop_now) last_pop_cyc = cyc;
        end
    end

    // Reference model: predicts the APB transfer and response bytes of one frame.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int ws, input bit err, input bit hang);
        logic [7:0]  sts;
        logic [31:0] rd;
        apb_exp_t    a;
        tx_exp_t     t;
        sts = hang ? 8'h02 : (err ? 8'h01 : 8'h00);
        cfg_ws = ws; cfg_err = err; cfg_hang = hang;
        a.addr = addr; a.wr = wr; a.wdata = data;
        a.sel_cyc = hang ? 1 + int'(APB_TMO) : 2 + ws;
        apb_q.push_back(a);
        rd = 32'h0;
        if (wr) begin
            if (sts == 8'h00) ref_mem[addr] = data;
        end else if (sts == 8'h00 && ref_mem.exists(addr)) begin
            rd = ref_mem[addr];
        end
        t.b = sts; t.first = 1;
        t.lat = (!hang && !tx_rand && !tx_hold) ? 3 + ws : -1;
        tx_q.push_back(t);
        if (!wr) for (int i = 3; i >= 0; i--) begin
            t.b = rd[i*8 +: 8]; t.first = 0; t.lat = -1;
            tx_q.push_back(t);
        end
        rxq.push_back(wr ? 8'h01 : 8'h00);
        for (int i = 3; i >= 0; i--) rxq.push_back(addr[i*8 +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) rxq.push_back(data[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((tx_q.size() != 0 || apb_q.size() != 0 || rxq.size() != 0) && n < 3000) begin
            @(posedge clk); n++;
        end
        n_checks++;
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL %s: timeout, got tx_q=%0d apb_q=%0d rxq=%0d, required all 0",
                     name, tx_q.size(), apb_q.size(), rxq.size());
            tx_q.delete(); apb_q.delete(); rxq.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int r, sz, n;
        rx_fifo_rd_data_valid = 0; rx_fifo_rd_data = 0; tx_fifo_wr_data_valid = 0;
        p_ready = 0; p_rdata = 0; p_slverr = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rx_req", rx_fifo_rd_data_req, 0);
        chk("rst_tx_req", tx_fifo_wr_data_req, 0);
        chk("rst_tx_data", tx_fifo_wr_data, 0);
        chk("rst_psel", p_sel, 0);
        chk("rst_penable", p_enable, 0);
        chk("rst_pwrite", p_write, 0);
        chk("rst_paddr", p_addr, 0);
        chk("rst_pwdata", p_wdata, 0);
        @(negedge clk); rst_n = 1;
        repeat (2) @(posedge clk);

        issue(1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0); wait_idle("wr_basic");
        issue(1, 32'h0000_2000, 32'h1234_5678, 0, 0, 0); wait_idle("wr_2000");
        issue(0, 32'h0000_2000, 32'h0, 3, 0, 0);         wait_idle("rd_3ws");
        issue(0, 32'h0000_1004, 32'h0, 1, 1, 0);         wait_idle("rd_slverr");
        issue(1, 32'h0000_1004, 32'h0BAD_0BAD, 0, 1, 0); wait_idle("wr_slverr");
        issue(1, 32'h0000_3000, 32'hCAFE_F00D, 0, 0, 1); wait_idle("wr_tmo");
        issue(0, 32'h0000_2000, 32'h0, 0, 0, 1);         wait_idle("rd_tmo");
        issue(0, 32'h0000_1004, 32'h0, 0, 0, 0);         wait_idle("rd_after_err");

        // Junk command then a partial frame left to expire; only the next read is answered.
        rxq.push_back(8'h7F); rxq.push_back(8'h00);
        rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'h10);
        n = 0;
        while (rxq.size() != 0 && n < 100) begin @(posedge clk); n++; end
        repeat (int'(RX_TMO) + 30) @(posedge clk);
        issue(0, 32'h0000_1004, 32'h0, 0, 0, 0);         wait_idle("rd_after_drop");

        // A gap shorter than the RX timeout keeps the frame alive.
        rx_keep = 3;
        issue(0, 32'h0000_2000, 32'h0, 2, 0, 0);
        repeat (int'(RX_TMO) - 20) @(posedge clk);
        rx_keep = 0;
        wait_idle("rd_slow_rx");

        // TX backpressure for 100 cycles with the next frame already waiting in the RX FIFO.
        tx_hold = 1;
        issue(0, 32'h0000_2000, 32'h0, 1, 0, 0);
        n = 0;
        while (apb_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        issue(1, 32'hA5A5_0010, 32'h5555_AAAA, 0, 0, 0);
        sz = rxq.size();
        repeat (100) @(posedge clk);
        chk("no_rx_pop_in_tx", rxq.size(), sz);
        chk("no_tx_push_while_full", tx_q.size(), 6);
        tx_hold = 0;
        wait_idle("rd_backpressure");

        rx_rand = 1; tx_rand = 1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 19);
            issue(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], $urandom,
                  $urandom_range(0, 3), r < 2, r == 2);
            wait_idle("rand");
        end
        rx_rand = 0; tx_rand = 0;

        // Reset in the middle of an ACCESS phase.
        issue(0, 32'h0000_2000, 32'h0, 0, 0, 1);
        n = 0;
        while (!p_enable && n < 100) begin @(posedge clk); n++; end
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("async_rst_psel", p_sel, 0);
        chk("async_rst_penable", p_enable, 0);
        chk("async_rst_tx_req", tx_fifo_wr_data_req, 0);
        tx_q.delete(); apb_q.delete(); rxq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1;
        repeat (2) @(posedge clk);
        issue(0, 32'h0000_2000, 32'h0, 2, 0, 0);         wait_idle("rd_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog");
    end

endmodule
